bcd_entry_display: RTL and testbench

- Sits directly downstream of the 10-switch decimal-to-BCD encoder.
- Debounces the encoder's 4-bit BCD code and accepts one digit per key press.
- Shifts accepted digits into a 4-digit entry register (calculator-style: newest digit on the right).
- Time-multiplexes the register onto a 4-digit common-anode seven-segment display.

---
 rtl/bcd_disp_pkg.sv | 20 ++
 rtl/bcd_entry_display_if.sv | 26 ++
 rtl/bcd_to_7seg.sv | 17 +
 rtl/bcd_entry_display.sv | 155 +++++++++++++++
 tb/tb_bcd_entry_display.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the BCD entry/display block.
package bcd_disp_pkg;

    localparam logic [3:0] BCD_IDLE  = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } state_t;

    // gfedcba, active-low, indexed by digit value
    localparam logic [6:0] SEG_TABLE [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_entry_display_if.sv
// Key-entry side signals: encoder code and clear in, accepted-digit status out.
interface bcd_entry_display_if;

    logic [3:0] bcd_in;
    logic       clear;
    logic       key_strobe;
    logic [3:0] key_code;
    logic [2:0] entry_count;

    modport master (
        output bcd_in,
        output clear,
        input  key_strobe,
        input  key_code,
        input  entry_count
    );

    modport slave (
        input  bcd_in,
        input  clear,
        output key_strobe,
        output key_code,
        output entry_count
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder with blanking.
module bcd_to_7seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && (bcd <= 4'd9)) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/bcd_entry_display.sv
// Debounced digit entry into a 4-digit shift register, scanned onto a
// multiplexed common-anode seven-segment display.
module bcd_entry_display
    import bcd_disp_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned REFRESH_DIV   = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_entry_display_if.slave   key_bus,
    output logic [6:0]           seg,
    output logic [3:0]           an,
    output logic                 dp
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned RW = $clog2(REFRESH_DIV);

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [3:0]      cap, cap_next;
    logic            code_valid, code_idle, same_code, cnt_done;
    logic            accept;

    logic [3:0]      digits [4];
    logic [2:0]      count;
    logic            strobe;
    logic [3:0]      code_reg;

    logic [RW-1:0]   ref_cnt;
    logic [1:0]      scan;
    logic [6:0]      seg_dec;
    logic            slot_blank;

    assign code_valid = (key_bus.bcd_in <= 4'd9);
    assign code_idle  = (key_bus.bcd_in == BCD_IDLE);
    assign same_code  = (key_bus.bcd_in == cap);
    assign cnt_done   = (cnt == CW'(STABLE_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cap   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cap   <= cap_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cap_next   = cap;
        case (state)
            IDLE: begin
                if (code_valid) begin
                    cap_next   = key_bus.bcd_in;
                    cnt_next   = CW'(1);
                    state_next = PRESS;
                end
            end
            PRESS: begin
                if (code_valid) begin
                    if (!same_code) begin
                        cap_next = key_bus.bcd_in;
                        cnt_next = CW'(1);
                    end else if (cnt_done) begin
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            HELD: begin
                if (code_idle) begin
                    cnt_next   = CW'(1);
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!code_idle) begin
                    state_next = HELD;
                end else if (cnt_done) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept = (state == PRESS) && code_valid && same_code && cnt_done;
    end

    // Clear beats a simultaneous accept: the FSM still moves on, but nothing is stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) digits[i] <= '0;
            count    <= '0;
            strobe   <= 1'b0;
            code_reg <= '0;
        end else begin
            strobe <= 1'b0;
            if (key_bus.clear) begin
                for (int unsigned i = 0; i < 4; i++) digits[i] <= '0;
                count <= '0;
            end else if (accept) begin
                for (int unsigned i = 1; i < 4; i++) digits[i] <= digits[i-1];
                digits[0] <= cap;
                count     <= (count == 3'd4) ? count : count + 3'd1;
                strobe    <= 1'b1;
                code_reg  <= cap;
            end
        end
    end

    assign slot_blank = ({1'b0, scan} >= count);

    bcd_to_7seg u_dec (
        .bcd   (digits[scan]),
        .blank (slot_blank),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt <= '0;
            scan    <= '0;
            an      <= '1;
            seg     <= SEG_BLANK;
        end else begin
            if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                scan    <= scan + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + RW'(1);
            end
            an  <= ~(4'b0001 << scan);
            seg <= seg_dec;
        end
    end

    assign dp                  = 1'b1;
    assign key_bus.key_strobe  = strobe;
    assign key_bus.key_code    = code_reg;
    assign key_bus.entry_count = count;

endmodule

// File: tb/tb_bcd_entry_display.sv
// Randomised and directed stimulus against a run-length reference model of digit entry.
module tb_bcd_entry_display;

    localparam int S   = 4;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    always #5 clk = ~clk;

    bcd_entry_display_if kb ();

    bcd_entry_display #(
        .STABLE_CYCLES (S),
        .REFRESH_DIV   (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_bus (kb),
        .seg     (seg),
        .an      (an),
        .dp      (dp)
    );

    int checks = 0;
    int errors = 0;

    // reference model state
    int n = 0;          // clock edges since reset release
    int dig[4];         // dig[0] is the rightmost digit
    int cnt_m = 0;
    int kc = 0;
    int run = 0;
    int run_code = 0;
    int frun = 0;
    bit down = 0;
    int strobes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic step(input logic [3:0] code, input bit clr);
        int         slot;
        logic [3:0] ean;
        logic [6:0] eseg;
        bit         acc;
        kb.bcd_in = code;
        kb.clear  = clr;
        slot = (n / DIV) % 4;
        ean  = 4'hF & ~(4'b0001 << slot);
        eseg = (slot < cnt_m) ? seg_code(dig[slot]) : 7'h7F;
        acc  = 1'b0;
        if (!down) begin
            if (code <= 4'd9) begin
                if (run > 0 && int'(code) == run_code) run++;
                else begin
                    run      = 1;
                    run_code = int'(code);
                end
                if (run == S + 1) begin
                    acc  = 1'b1;
                    down = 1'b1;
                    frun = 0;
                end
            end else begin
                run = 0;
            end
        end else begin
            if (code == 4'hF) begin
                frun++;
                if (frun == S + 1) begin
                    down = 1'b0;
                    run  = 0;
                end
            end else begin
                frun = 0;
            end
        end
        @(posedge clk);
        #1;
        n++;
        if (clr) begin
            for (int i = 0; i < 4; i++) dig[i] = 0;
            cnt_m = 0;
        end else if (acc) begin
            for (int i = 3; i > 0; i--) dig[i] = dig[i-1];
            dig[0] = run_code;
            if (cnt_m < 4) cnt_m++;
            kc = run_code;
        end
        check("an", 32'(an), 32'(ean));
        check("seg", 32'(seg), 32'(eseg));
        check("dp", 32'(dp), 32'd1);
        check("key_strobe", 32'(kb.key_strobe), 32'(acc && !clr));
        check("key_code", 32'(kb.key_code), 32'(kc));
        check("entry_count", 32'(kb.entry_count), 32'(cnt_m));
        if (kb.key_strobe) strobes++;
    endtask

    task automatic hold(input logic [3:0] code, input int len);
        for (int i = 0; i < len; i++) step(code, 1'b0);
    endtask

    initial begin
        int lat;
        int base;
        logic [3:0] code;

        for (int i = 0; i < 4; i++) dig[i] = 0;
        rst_n     = 1'b0;
        kb.bcd_in = 4'hF;
        kb.clear  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_an", 32'(an), 32'hF);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_strobe", 32'(kb.key_strobe), 32'd0);
        check("rst_key_code", 32'(kb.key_code), 32'd0);
        check("rst_count", 32'(kb.entry_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // idle scan: all blank, anodes rotate
        hold(4'hF, 40);
        check("idle_strobes", 32'(strobes), 32'd0);

        // single press with latency measurement
        base = strobes;
        lat  = -1;
        for (int i = 1; i <= 10; i++) begin
            step(4'd5, 1'b0);
            if (kb.key_strobe && lat < 0) lat = i;
        end
        check("press_latency", 32'(lat), 32'(S + 1));
        hold(4'hF, 34);
        check("single_strobes", 32'(strobes - base), 32'd1);
        check("single_code", 32'(kb.key_code), 32'd5);

        // bounce, long hold, bounce during release
        base = strobes;
        step(4'd3, 1'b0); step(4'hF, 1'b0); step(4'd3, 1'b0); step(4'hF, 1'b0);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            step(4'd3, 1'b0);
            if (kb.key_strobe && lat < 0) lat = i;
        end
        check("bounce_latency", 32'(lat), 32'(S + 1));
        step(4'hF, 1'b0); step(4'hF, 1'b0); step(4'd3, 1'b0); step(4'hF, 1'b0); step(4'd3, 1'b0);
        hold(4'd7, 3);
        hold(4'hF, 10);
        check("bounce_strobes", 32'(strobes - base), 32'd1);

        // overflow: oldest digit drops off
        base = strobes;
        foreach (dig[i]) ;
        hold(4'd1, 6); hold(4'hF, 8);
        hold(4'd2, 6); hold(4'hF, 8);
        hold(4'd3, 6); hold(4'hF, 8);
        hold(4'd4, 6); hold(4'hF, 8);
        hold(4'd9, 6); hold(4'hF, 8);
        check("overflow_strobes", 32'(strobes - base), 32'd5);
        check("overflow_count", 32'(kb.entry_count), 32'd4);
        hold(4'hF, 40);

        // invalid codes abort a press
        base = strobes;
        hold(4'd7, 2); step(4'hA, 1'b0); hold(4'hF, 4);
        for (int c = 10; c < 15; c++) hold(4'(c), 3);
        hold(4'd7, 3); step(4'hE, 1'b0); hold(4'd7, 3); hold(4'hF, 6);
        check("invalid_strobes", 32'(strobes - base), 32'd0);

        // clear on the accept cycle wins
        base = strobes;
        hold(4'd8, S);
        step(4'd8, 1'b1);
        hold(4'd8, 3);
        hold(4'hF, 8);
        check("clear_strobes", 32'(strobes - base), 32'd0);
        check("clear_count", 32'(kb.entry_count), 32'd0);
        hold(4'hF, 32);
        hold(4'd6, 6); hold(4'hF, 8);
        check("after_clear_count", 32'(kb.entry_count), 32'd1);
        check("after_clear_code", 32'(kb.key_code), 32'd6);
        hold(4'hF, 32);

        // randomised presses, bounces, invalid codes and clears
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 9))
                0:       code = 4'(10 + $urandom_range(0, 4));
                default: code = 4'($urandom_range(0, 9));
            endcase
            for (int i = 0; i < int'($urandom_range(1, 9)); i++) begin
                if ($urandom_range(0, 11) == 0) step(4'($urandom_range(0, 15)), 1'b0);
                else step(code, ($urandom_range(0, 19) == 0));
            end
            for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                step(4'hF, ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
